// File: rtl/wave_capture_if.sv
// Bundles the sample-pipeline inputs and wave RAM write port of wave_capture.
interface wave_capture_if;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/wave_capture.sv
// Captures a 256-sample window per positive-going zero crossing into the
// ping-pong half the display is not reading, then swaps halves when idle.
module wave_capture (
  input logic        clk,
  input logic        reset,
  wave_capture_if.slave bus
);
  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_index;
  logic       r_prev_msb;
  logic       r_read_index;

  logic       w_crossing;
  logic       w_we;

  assign w_crossing = bus.new_sample_ready & r_prev_msb & ~bus.new_sample_in[15];
  assign w_we       = bus.new_sample_ready &
                      ((r_state == ACTIVE) | ((r_state == ARMED) & w_crossing));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ARMED;
      r_index      <= '0;
      r_prev_msb   <= 1'b0;
      r_read_index <= 1'b0;
    end else begin
      if (bus.new_sample_ready) r_prev_msb <= bus.new_sample_in[15];
      case (r_state)
        ARMED: begin
          // The crossing sample itself occupies slot 0.
          if (w_crossing) begin
            r_state <= ACTIVE;
            r_index <= 8'd1;
          end
        end
        ACTIVE: begin
          if (bus.new_sample_ready) begin
            r_index <= r_index + 8'd1;
            if (r_index == 8'hFF) r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.wave_display_idle) begin
            r_read_index <= ~r_read_index;
            r_state      <= ARMED;
          end
        end
        default: r_state <= ARMED;
      endcase
    end
  end

  assign bus.write_enable  = w_we;
  assign bus.write_address = {~r_read_index, r_index};
  assign bus.write_sample  = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};
  assign bus.read_index    = r_read_index;
endmodule

// File: tb/tb_wave_capture.sv
// Randomised scoreboard bench for wave_capture against a window-level model.
module tb_wave_capture;
  logic clk;
  logic reset;
  wave_capture_if bus ();

  wave_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [16:0] exp_q[$];

  // Model: m_fill = -1 waiting for crossing, 0..255 samples taken, 256 full.
  int m_fill;
  bit m_prev_neg;
  bit m_ri;

  function automatic void model_reset();
    m_fill     = -1;
    m_prev_neg = 1'b0;
    m_ri       = 1'b0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rdy, input logic [15:0] s, input logic idl);
    int  sv;
    int  pos;
    int  addr;
    int  smp;
    bit  wr;
    bus.new_sample_ready  = rdy;
    bus.new_sample_in     = s;
    bus.wave_display_idle = idl;
    sv = int'($signed(s));
    chk("read_index", int'(bus.read_index), int'(m_ri));
    wr  = 1'b0;
    pos = 0;
    if (rdy) begin
      if (m_fill >= 0 && m_fill < 256) begin
        wr  = 1'b1;
        pos = m_fill;
      end else if (m_fill == -1 && m_prev_neg && sv >= 0) begin
        wr  = 1'b1;
        pos = 0;
      end
    end
    if (wr) begin
      addr = (m_ri ? 0 : 256) + pos;
      smp  = (sv + 32768) / 256;
      exp_q.push_back({addr[8:0], smp[7:0]});
      m_fill = pos + 1;
    end
    if (m_fill == 256 && idl) begin
      m_ri   = ~m_ri;
      m_fill = -1;
    end
    if (rdy) m_prev_neg = (sv < 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && bus.write_enable) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h sample 0x%0h, required none at %0t",
                 bus.write_address, bus.write_sample, $time);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("write_address", int'(bus.write_address), int'(e[16:8]));
        chk("write_sample", int'(bus.write_sample), int'(e[7:0]));
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.new_sample_ready  = 1'b1;
    bus.new_sample_in     = 16'h0100;
    bus.wave_display_idle = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_read_index", int'(bus.read_index), 0);
    chk("reset_write_enable", int'(bus.write_enable), 0);
    reset = 1'b1;

    cycle(1'b1, 16'h7FFF, 1'b0);
    cycle(1'b1, 16'hFFFF, 1'b0);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = 16'h0100;
    #1;
    chk("crossing_we", int'(bus.write_enable), 1);
    chk("crossing_addr", int'(bus.write_address), 9'h100);
    chk("crossing_sample", int'(bus.write_sample), 8'h81);
    cycle(1'b1, 16'h0100, 1'b0);
    for (int unsigned i = 0; i < 255; i++)
      cycle(1'b1, 16'($urandom), 1'b0);
    cycle(1'b1, 16'h8000, 1'b0);
    cycle(1'b1, 16'h0100, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("swap_read_index", int'(bus.read_index), 1);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);

    cycle(1'b1, 16'h8000, 1'b1);
    cycle(1'b1, 16'h7FFF, 1'b1);
    for (int unsigned i = 0; i < 255; i++)
      cycle(1'b1, 16'($urandom), ($urandom_range(0, 7) == 0));
    repeat (3) cycle(1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    chk("swap_back_read_index", int'(bus.read_index), 0);

    cycle(1'b1, 16'hFFFF, 1'b0);
    cycle(1'b1, 16'h0000, 1'b0);
    for (int unsigned i = 0; i < 36; i++)
      cycle(1'b1, 16'($urandom), 1'b0);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = 16'h1234;
    #1;
    reset = 1'b0;
    #1;
    chk("midreset_write_enable", int'(bus.write_enable), 0);
    chk("midreset_read_index", int'(bus.read_index), 0);
    chk("midreset_address", int'(bus.write_address), 9'h100);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int unsigned i = 0; i < 4000; i++)
      cycle(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 15) == 0));
    cycle(1'b0, 16'h0000, 1'b0);

    chk("pending_writes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
